mem_arbiter: RTL



---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_select.sv | 30 +++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states and owner codes.
// Imported by mem_arbiter and arb_select.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_ACCESS = 2'b01,
        ARB_DONE   = 2'b10
    } arbState_e;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CORE = 2'b01;
    localparam logic [1:0] OWN_LDR  = 2'b10;

endpackage

// File: rtl/mem_arbiter_select.sv
// Combinational winner selection between the core and loader requests.
// ARB_ROUND_ROBIN_EN selects round-robin tie breaking; otherwise the loader always wins ties.
import mem_arbiter_pkg::*;

module arb_select (
    input  logic       core_req_i,
    input  logic       ldr_req_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic       last_ldr_i,
`endif
    output logic [1:0] winner_o
);

    always_comb begin
        winner_o = OWN_NONE;
        if (core_req_i && ldr_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            // On a tie the port that did not win the previous grant goes next.
            winner_o = last_ldr_i ? OWN_CORE : OWN_LDR;
`else
            winner_o = OWN_LDR;
`endif
        end else if (ldr_req_i) begin
            winner_o = OWN_LDR;
        end else if (core_req_i) begin
            winner_o = OWN_CORE;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (core / program loader) for the unified memory, one access at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed loader priority.
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ack,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        owner,
    output logic              busy
);

    arbState_e  state_q;
    logic [1:0] winner_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic lastLdr_q;
`endif

    arb_select u_select (
        .core_req_i (core_req),
        .ldr_req_i  (ldr_req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_ldr_i (lastLdr_q),
`endif
        .winner_o   (winner_d)
    );

    // Every output is a flop, so requester inputs and mem_ready never reach an output combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rdata <= '0;
            ldr_rdata  <= '0;
            core_ack   <= 1'b0;
            ldr_ack    <= 1'b0;
            owner      <= OWN_NONE;
            busy       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            lastLdr_q  <= 1'b0;
`endif
        end else begin
            core_ack <= 1'b0;
            ldr_ack  <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (winner_d != OWN_NONE) begin
                        state_q <= ARB_ACCESS;
                        owner   <= winner_d;
                        busy    <= 1'b1;
                        mem_req <= 1'b1;
                        if (winner_d == OWN_LDR) begin
                            mem_we    <= ldr_we;
                            mem_addr  <= ldr_addr;
                            mem_wdata <= ldr_wdata;
                        end else begin
                            mem_we    <= core_we;
                            mem_addr  <= core_addr;
                            mem_wdata <= core_wdata;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        lastLdr_q <= (winner_d == OWN_LDR);
`endif
                    end
                end
                ARB_ACCESS: begin
                    if (mem_ready) begin
                        state_q <= ARB_DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (owner == OWN_LDR) begin
                            ldr_ack <= 1'b1;
                            if (!mem_we) ldr_rdata <= mem_rdata;
                        end else begin
                            core_ack <= 1'b1;
                            if (!mem_we) core_rdata <= mem_rdata;
                        end
                    end
                end
                ARB_DONE: begin
                    state_q <= ARB_IDLE;
                    owner   <= OWN_NONE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= ARB_IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    owner   <= OWN_NONE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
